bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Arbitrates the shared serial bus (b_BUS/b_RW/b_util) between NUM_MASTERS bus masters.
//  Each master (ext_interface and others) drives b_request; the arbiter returns a one-hot grant.
//  It watches b_util to track bus ownership and force-releases stalled owners by watchdog.
//  Sits at the top level beside the slave array; one instance per bus.
// PARAMETERS
//  NUM_MASTERS  3  number of requesters (2..8)
//  TIMEOUT_LEN  6  watchdog counter width in bits; timeout when count reaches 2**TIMEOUT_LEN-1
//  GRANT_GAP    2  idle cycles forced between release and next grant (>=1)
// PORTS
//  clk          in   1            clock, all logic on posedge
//  rstn         in   1            async active-low reset
//  m_request    in   NUM_MASTERS  per-master bus request, level, held until done
//  b_util       in   1            bus-utilizing line (wired bus), high while owner transacts
//  m_grant      out  NUM_MASTERS  one-hot grant, registered
//  grant_id     out  3            index of current/last granted master
//  bus_busy     out  1            high in any state except IDLE
//  timeout_err  out  1            1-cycle pulse on any watchdog expiry
// BEHAVIOUR
//  Reset: state=IDLE, m_grant=0, grant_id=0, bus_busy=0, timeout_err=0, rr_ptr=0, wd_cnt=0.
//  States: IDLE -> GRANT_WAIT -> OWNED -> GAP -> IDLE.
//  IDLE: if |m_request, pick winner, m_grant<=onehot(winner), grant_id<=winner, wd_cnt<=0,
//   go GRANT_WAIT. Grant is visible 1 cycle after request is sampled high.
//  Winner (default): round-robin, first set bit scanning from rr_ptr upward with wrap at
//   NUM_MASTERS-1 -> 0; rr_ptr<=winner+1 (mod NUM_MASTERS) at grant time.
//  GRANT_WAIT: b_util==1 -> OWNED, wd_cnt<=0. m_request[grant_id]==0 -> GAP (no error).
//   wd_cnt==all-ones -> GAP, timeout_err pulse. Else wd_cnt++.
//   Priority when simultaneous: b_util > request-drop > timeout.
//  OWNED: b_util falls to 0 -> GAP. m_request[grant_id] drop alone does not release.
//   wd_cnt==all-ones with b_util still 1 -> GAP, timeout_err pulse. Else wd_cnt++.
//   wd_cnt is cleared on every state entry; it counts only in GRANT_WAIT/OWNED.
//  GAP: m_grant<=0 on entry cycle; hold GRANT_GAP cycles total, then IDLE. New requests
//   arriving during GAP wait; they are arbitrated in IDLE on the following cycle.
//  Grants are never changed other than 0 <-> one-hot; two bits are never set at once.
//  Requests from non-granted masters never affect the current owner (no preemption).
//  A master re-requesting right after its own release loses to any other pending requester
//   (round-robin) and wins only if alone.
//  b_util high while IDLE (rogue driver): ignored, no grant change, no error.
//  rstn low mid-transaction: m_grant drops to 0 asynchronously, state IDLE.
//  grant_id holds last winner after release; it is valid while m_grant!=0.
// CONFIGURATION
//  Macro ARB_FIXED_PRIORITY_EN:
//   defined: winner = lowest-index set bit of m_request; rr_ptr unused (held at 0).
//   undefined: round-robin as above (default build).
//  All other behaviour identical in both builds.
// TESTING
//  1 Single req: m_request=3'b010 at t0 -> m_grant=3'b010 at t0+1; b_util 1 for 20 cyc, then 0
//    -> m_grant=0 next cycle, bus_busy low after GRANT_GAP=2 more cycles.
//  2 Round-robin: m_request=3'b111 held, each owner pulses b_util 5 cyc -> grant order
//    m0,m1,m2,m0; with ARB_FIXED_PRIORITY_EN -> m0 every time.
//  3 No-show: req m2, b_util never rises -> grant dropped after 63 cyc (TIMEOUT_LEN=6),
//    timeout_err 1 cycle, next pending master granted after gap.
//  4 Hog: owner holds b_util 100 cyc -> forced release at 63 cyc, timeout_err pulse,
//    m_grant=0; stays OWNED-free (no regrant to same master while others pending).
//  5 Withdraw: req m1, drop m_request in GRANT_WAIT before b_util -> GAP, no timeout_err.
//  6 Reset mid-OWNED: rstn low -> m_grant=0 immediately; after release, req m2 with
//    rr_ptr=0 -> grant m2 one cycle later.
//  Checkers: $onehot0(m_grant) every cycle; grant only changes via 0.

Source files
------------

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Grants the shared serial bus to one of NUM_MASTERS requesters
//               at a time. Tracks ownership through the wired b_util line and
//               force-releases owners that never start or never finish
//               (watchdog). A fixed number of idle cycles separate a release
//               from the next grant.
//               Build option: define ARB_FIXED_PRIORITY_EN to select the
//               lowest-index requester instead of round-robin arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int TIMEOUT_LEN = 6,
    parameter int GRANT_GAP   = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] m_request,
    input  logic                   b_util,
    output logic [NUM_MASTERS-1:0] m_grant,
    output logic [2:0]             grant_id,
    output logic                   bus_busy,
    output logic                   timeout_err
);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_GRANT_WAIT = 2'd1;
    localparam logic [1:0] c_OWNED      = 2'd2;
    localparam logic [1:0] c_GAP        = 2'd3;

    localparam logic [TIMEOUT_LEN-1:0] c_WD_MAX  = {TIMEOUT_LEN{1'b1}};
    localparam int                     c_GAP_W   = (GRANT_GAP > 1) ? $clog2(GRANT_GAP) : 1;
    localparam logic [c_GAP_W-1:0]     c_GAP_LAST = c_GAP_W'(GRANT_GAP - 1);
    localparam logic [2:0]             c_LAST_ID = 3'(NUM_MASTERS - 1);

    logic [1:0]             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [2:0]             r_grant_id;
    logic                   r_busy;
    logic                   r_timeout;
    logic [TIMEOUT_LEN-1:0] r_wd_cnt;
    logic [c_GAP_W-1:0]     r_gap_cnt;

    logic [NUM_MASTERS-1:0] w_rot;
    logic [2:0]             w_off;
    logic [2:0]             w_winner;
    logic [NUM_MASTERS-1:0] w_onehot;
    logic                   w_owner_req;

`ifdef ARB_FIXED_PRIORITY_EN
    // Fixed priority: scan the raw request vector from index 0
    assign w_rot    = m_request;
    assign w_winner = w_off;
`else
    logic [2:0] r_rr_ptr;
    logic [2:0] w_next_ptr;
    logic [3:0] w_sum;

    // Rotate requests so bit 0 corresponds to the master at the pointer
    assign w_rot = NUM_MASTERS'({m_request, m_request} >> r_rr_ptr);

    // Map the rotated offset back to a master index, wrapping past the last one
    always_comb begin
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        if (w_sum >= 4'(NUM_MASTERS)) begin
            w_sum = w_sum - 4'(NUM_MASTERS);
        end
        w_winner = w_sum[2:0];
    end

    assign w_next_ptr = (w_winner == c_LAST_ID) ? 3'd0 : w_winner + 3'd1;

    // Pointer advances past each winner so the next search starts after it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr <= 3'd0;
        end else if (r_state == c_IDLE && |m_request) begin
            r_rr_ptr <= w_next_ptr;
        end
    end
`endif

    // Lowest set bit of the (rotated) request vector
    always_comb begin
        w_off = 3'd0;
        for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = 3'(j);
            end
        end
    end

    // Decode the winner into a one-hot grant pattern
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_onehot[i] = (w_winner == 3'(i));
        end
    end

    // Request line of the master currently holding the grant
    always_comb begin
        w_owner_req = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant_id == 3'(i)) begin
                w_owner_req = m_request[i];
            end
        end
    end

    // Ownership state machine with watchdog and post-release idle gap
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= c_IDLE;
            r_grant    <= '0;
            r_grant_id <= 3'd0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_wd_cnt   <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    // b_util is deliberately ignored here: a rogue driver must not start anything
                    if (|m_request) begin
                        r_grant    <= w_onehot;
                        r_grant_id <= w_winner;
                        r_wd_cnt   <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= c_GRANT_WAIT;
                    end
                end
                c_GRANT_WAIT: begin
                    if (b_util) begin
                        r_wd_cnt <= '0;
                        r_state  <= c_OWNED;
                    end else if (!w_owner_req) begin
                        r_grant   <= '0;
                        r_wd_cnt  <= '0;
                        r_gap_cnt <= '0;
                        r_state   <= c_GAP;
                    end else if (r_wd_cnt == c_WD_MAX) begin
                        r_grant   <= '0;
                        r_wd_cnt  <= '0;
                        r_gap_cnt <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= c_GAP;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                c_OWNED: begin
                    // Only the bus line ends ownership; a dropped request does not
                    if (!b_util) begin
                        r_grant   <= '0;
                        r_wd_cnt  <= '0;
                        r_gap_cnt <= '0;
                        r_state   <= c_GAP;
                    end else if (r_wd_cnt == c_WD_MAX) begin
                        r_grant   <= '0;
                        r_wd_cnt  <= '0;
                        r_gap_cnt <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= c_GAP;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                c_GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign m_grant     = r_grant;
    assign grant_id    = r_grant_id;
    assign bus_busy    = r_busy;
    assign timeout_err = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter: directed scenarios
//               (single request, round-robin, no-show and hog watchdogs,
//               withdraw, reset mid-ownership, rogue b_util) followed by
//               randomized transactions checked against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int N     = 3;
    localparam int TL    = 6;
    localparam int GG    = 2;
    localparam int WDMAX = (1 << TL) - 1;

    logic         clk = 1'b0;
    logic         rstn;
    logic [N-1:0] m_request;
    logic         b_util;
    logic [N-1:0] m_grant;
    logic [2:0]   grant_id;
    logic         bus_busy;
    logic         timeout_err;

    int n_assert = 0;
    int n_fail   = 0;
    int m_rr     = 0;

    bus_arbiter #(
        .NUM_MASTERS (N),
        .TIMEOUT_LEN (TL),
        .GRANT_GAP   (GG)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .m_request   (m_request),
        .b_util      (b_util),
        .m_grant     (m_grant),
        .grant_id    (grant_id),
        .bus_busy    (bus_busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Reference arbitration rule: which master wins a given request vector
    function automatic int pick(input logic [N-1:0] req);
        int idx;
`ifdef ARB_FIXED_PRIORITY_EN
        for (int k = 0; k < N; k++) begin
            if (((int'(req) >> k) & 1) == 1) return k;
        end
`else
        for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (((int'(req) >> idx) & 1) == 1) return idx;
        end
`endif
        idx = -1;
        return idx;
    endfunction

    task automatic upd(input int w);
`ifdef ARB_FIXED_PRIORITY_EN
        m_rr = 0 * w;
`else
        m_rr = (w + 1) % N;
`endif
    endtask

    function automatic logic [N-1:0] onehot(input int w);
        return {{(N-1){1'b0}}, 1'b1} << w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [N-1:0] eg, input logic eb, input logic et);
        n_assert++;
        assert (m_grant === eg) else begin
            n_fail++;
            $error("FAIL %s m_grant: observed %b expected %b", tag, m_grant, eg);
        end
        n_assert++;
        assert (bus_busy === eb) else begin
            n_fail++;
            $error("FAIL %s bus_busy: observed %b expected %b", tag, bus_busy, eb);
        end
        n_assert++;
        assert (timeout_err === et) else begin
            n_fail++;
            $error("FAIL %s timeout_err: observed %b expected %b", tag, timeout_err, et);
        end
    endtask

    task automatic chk_gid(input string tag, input int exp);
        n_assert++;
        assert (int'(grant_id) === exp) else begin
            n_fail++;
            $error("FAIL %s grant_id: observed %0d expected %0d", tag, grant_id, exp);
        end
    endtask

    // Owner holds b_util for 'hold' cycles, then releases; checks the gap
    task automatic serve(input string tag, input int w, input int hold);
        b_util = 1'b1;
        step();
        repeat (hold - 1) step();
        chk_out({tag, "_hold"}, onehot(w), 1'b1, 1'b0);
        b_util = 1'b0;
        step();
        chk_out({tag, "_release"}, '0, 1'b1, 1'b0);
        chk_gid({tag, "_gid_kept"}, w);
        step();
        chk_out({tag, "_gap"}, '0, 1'b1, 1'b0);
        step();
        chk_out({tag, "_idle"}, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        m_request = '0;
        b_util    = 1'b0;
        #1;
        chk_out("reset_async", '0, 1'b0, 1'b0);
        step();
        rstn = 1'b1;
        m_rr = 0;
        step();
    endtask

    // Grant legality on every cycle: at most one bit, and changes only through zero
    logic [N-1:0] prev_g = '0;
    always @(negedge clk) begin
        n_assert++;
        assert ($onehot0(m_grant) && (prev_g == '0 || m_grant == '0 || m_grant == prev_g)) else begin
            n_fail++;
            $error("FAIL grant_legal: observed %b after %b expected one-hot or zero, changing via zero", m_grant, prev_g);
        end
        prev_g = m_grant;
    end

    initial begin
        int           w;
        int           kind;
        int           d;
        int           h;
        int           order [4];
        logic [N-1:0] r;
        logic [N-1:0] oh;

`ifdef ARB_FIXED_PRIORITY_EN
        order = '{0, 0, 0, 0};
`else
        order = '{0, 1, 2, 0};
`endif

        rstn      = 1'b0;
        m_request = '0;
        b_util    = 1'b0;
        step();
        step();
        chk_out("reset", '0, 1'b0, 1'b0);
        chk_gid("reset", 0);
        rstn = 1'b1;
        step();
        chk_out("idle_after_reset", '0, 1'b0, 1'b0);

        // Rogue b_util while idle is ignored
        b_util = 1'b1;
        repeat (4) step();
        chk_out("rogue_util", '0, 1'b0, 1'b0);
        b_util = 1'b0;
        step();

        // Single request: grant one cycle later, 20-cycle ownership
        m_request = 3'b010;
        step();
        chk_out("t1_grant", 3'b010, 1'b1, 1'b0);
        chk_gid("t1_gid", 1);
        upd(1);
        serve("t1", 1, 20);

        // Round-robin with all masters continuously requesting
        do_reset();
        m_request = 3'b111;
        for (int k = 0; k < 4; k++) begin
            step();
            w = pick(m_request);
            chk_out($sformatf("t2_grant%0d", k), onehot(w), 1'b1, 1'b0);
            chk_gid($sformatf("t2_order%0d", k), order[k]);
            upd(w);
            serve("t2", w, 5);
        end

        // No-show: master 2 granted but never drives b_util
        do_reset();
        m_request = 3'b100;
        step();
        w = pick(m_request);
        chk_out("t3_grant", 3'b100, 1'b1, 1'b0);
        upd(w);
        m_request = 3'b101;
        repeat (WDMAX) step();
        chk_out("t3_before_timeout", 3'b100, 1'b1, 1'b0);
        step();
        chk_out("t3_timeout", '0, 1'b1, 1'b1);
        step();
        chk_out("t3_pulse_end", '0, 1'b1, 1'b0);
        step();
        chk_out("t3_idle", '0, 1'b0, 1'b0);
        step();
        w = pick(m_request);
        chk_out("t3_next_grant", onehot(w), 1'b1, 1'b0);
        chk_gid("t3_next_gid", w);
        upd(w);

        // Hog: owner never releases b_util
        b_util = 1'b1;
        step();
        repeat (WDMAX) step();
        chk_out("t4_before_timeout", onehot(w), 1'b1, 1'b0);
        step();
        chk_out("t4_timeout", '0, 1'b1, 1'b1);
        b_util = 1'b0;
        step();
        chk_out("t4_pulse_end", '0, 1'b1, 1'b0);
        step();
        chk_out("t4_idle", '0, 1'b0, 1'b0);
        step();
        w = pick(m_request);
        chk_out("t4_next_grant", onehot(w), 1'b1, 1'b0);
        chk_gid("t4_next_gid", w);
        upd(w);

        // Withdraw: owner drops its request before driving b_util
        m_request = m_request & ~onehot(w);
        step();
        chk_out("t5_withdraw", '0, 1'b1, 1'b0);
        step();
        step();
        chk_out("t5_idle", '0, 1'b0, 1'b0);

        // Reset while a master owns the bus
        do_reset();
        m_request = 3'b010;
        step();
        chk_out("t6_grant", 3'b010, 1'b1, 1'b0);
        b_util = 1'b1;
        step();
        repeat (3) step();
        #2;
        rstn = 1'b0;
        #1;
        chk_out("t6_async_reset", '0, 1'b0, 1'b0);
        chk_gid("t6_async_reset", 0);
        m_request = '0;
        b_util    = 1'b0;
        step();
        step();
        rstn = 1'b1;
        m_rr = 0;
        step();
        m_request = 3'b100;
        step();
        chk_out("t6_regrant", 3'b100, 1'b1, 1'b0);
        chk_gid("t6_regrant", 2);
        upd(2);
        m_request = '0;
        step();
        step();
        step();
        chk_out("t6_idle", '0, 1'b0, 1'b0);

        // Randomized transactions against the reference rule
        do_reset();
        for (int t = 0; t < 40; t++) begin
            r = N'($urandom_range(1, (1 << N) - 1));
            m_request = r;
            step();
            w  = pick(r);
            oh = onehot(w);
            chk_out($sformatf("rnd%0d_grant", t), oh, 1'b1, 1'b0);
            chk_gid($sformatf("rnd%0d_gid", t), w);
            upd(w);
            m_request = (N'($urandom) & ~oh) | oh;
            kind = $urandom_range(0, 3);
            d    = $urandom_range(0, 5);
            repeat (d) step();
            chk_out($sformatf("rnd%0d_wait", t), oh, 1'b1, 1'b0);
            if (kind == 0) begin
                m_request = m_request & ~oh;
                step();
            end else begin
                b_util = 1'b1;
                step();
                h = $urandom_range(1, 10);
                repeat (h) begin
                    m_request = N'($urandom) & ~oh | (($urandom_range(0, 3) == 0) ? '0 : oh);
                    step();
                end
                chk_out($sformatf("rnd%0d_owned", t), oh, 1'b1, 1'b0);
                b_util = 1'b0;
                step();
            end
            chk_out($sformatf("rnd%0d_release", t), '0, 1'b1, 1'b0);
            step();
            chk_out($sformatf("rnd%0d_gap", t), '0, 1'b1, 1'b0);
            step();
            chk_out($sformatf("rnd%0d_idle", t), '0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
